writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Writer side of the core's 32x32 register file: final pipeline stage.
- Captures MEM-stage results into a MEM/WB register and selects the writeback value (ALU result, formatted load data, or PC+4).
- Drives the register file write port (A3/WD3/WE3) exactly once per retired instruction.
- Maintains a retired-instruction counter.

Parameters:
XLEN, 32, datapath width
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
mem_valid  input  1  MEM stage holds a real instruction
mem_reg_write  input  1  instruction writes rd
mem_rd  input  5  destination register index
mem_result_src  input  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU
mem_funct3  input  3  load width/sign encoding
mem_alu_result  input  XLEN  ALU result; bits [1:0] are the load byte address
mem_read_data  input  XLEN  aligned 32-bit word from data memory
mem_pc_plus4  input  XLEN  link value
stall  input  1  hold MEM/WB register (no capture)
flush  input  1  kill MEM/WB entry
A3  output  5  register file write index
WD3  output  XLEN  register file write data
WE3  output  1  register file write enable
wb_valid  output  1  MEM/WB register holds a valid, not-yet-retired entry
instret  output  CNT_W  retired-instruction count

Behaviour:
- State: wb_valid_q, wb_reg_write_q, wb_rd_q, wb_data_q (already formatted), done_q.
- Reset (rst=1 at clock edge): all state cleared to 0, instret=0. Outputs during and after reset: A3=0, WD3=0, WE3=0, wb_valid=0.
- WE3 is also gated combinationally by !rst, so no write can occur in a reset cycle.
- Priority per edge: rst > flush > stall > capture.
- flush: wb_valid_q <= 0, done_q <= 0. If flush and stall are both high, flush wins.
- stall: all MEM/WB state holds. done_q <= 1 if the entry retired this cycle.
- Capture (no rst/flush/stall): wb_valid_q <= mem_valid; rd, reg_write and the formatted data are loaded; done_q <= 0.
- Latency: a MEM value captured at edge N drives WE3/WD3 during cycle N..N+1. The register file writes it at edge N+1.
- Retire condition: retire = wb_valid_q & !done_q & !rst.
- WE3 = retire & wb_reg_write_q & (wb_rd_q != 0). Writes to x0 are never issued.
- A3 = wb_rd_q and WD3 = wb_data_q whenever wb_valid_q=1; both are 0 otherwise.
- wb_valid = retire.
- An entry retires exactly once even if held by stall across many cycles: after its first retire cycle done_q=1, and WE3 stays low until the next capture.
- instret increments by 1 on every edge where retire=1, independent of reg_write. It wraps modulo 2^CNT_W.
- Result select: 00/11 -> mem_alu_result; 10 -> mem_pc_plus4; 01 -> load format below.
- Load format, a = mem_alu_result[1:0]:
  - 000 LB: byte lane a, sign-extended.
  - 100 LBU: byte lane a, zero-extended.
  - 001 LH: halfword lane a[1], sign-extended. a[0] is ignored (misaligned loads not trapped here).
  - 101 LHU: halfword lane a[1], zero-extended.
  - 010 LW and 011/110/111: full word.
- A3/WD3/WE3 are also the WB forwarding source for the hazard unit. They are valid combinationally in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_valid=1, mem_reg_write=1, mem_rd=5 -> WE3=0 throughout, instret=0; first capture after rst falls gives WE3=1, A3=5.
- ALU writeback: mem_result_src=00, mem_rd=3, mem_alu_result=0x0000_1234 -> next cycle A3=3, WD3=0x0000_1234, WE3=1 for one cycle; instret 0->1.
- Loads: mem_read_data=0x80FF_7F01. LB a=3 -> 0xFFFF_FF80; LBU a=1 -> 0x0000_007F; LH a=2 -> 0xFFFF_80FF; LHU a=0 -> 0x0000_7F01; LW -> 0x80FF_7F01.
- x0 and stall: mem_rd=0, reg_write=1 -> WE3=0 but instret increments. Then an entry with rd=7 held by stall for 4 cycles -> WE3 high on exactly one cycle, instret +1 only.
- Flush/stall priority: flush=1 and stall=1 on the same edge with a valid entry held -> wb_valid=0, WE3=0 next cycle, instret unchanged.
- JAL link and wrap: mem_result_src=10, mem_pc_plus4=0x0000_0104, rd=1 -> WD3=0x0000_0104. With CNT_W=4, 17 retires -> instret=1.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, result select/load format, regfile write port and retire counter
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_result_src,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_read_data,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic             stall,
  input  logic             flush,
  output logic [4:0]       A3,
  output logic [XLEN-1:0]  WD3,
  output logic             WE3,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret
);
  logic             wb_valid_q, wb_valid_d;
  logic             wb_reg_write_q, wb_reg_write_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       a;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;
  logic [XLEN-1:0]  ld_val, sel_val;
  logic             retire, show;
  // Load formatting and writeback value selection; a[0] is ignored for halfwords
  always_comb begin
    a       = mem_alu_result[1:0];
    ld_b    = mem_read_data[{a, 3'b000} +: 8];
    ld_h    = a[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    ld_val  = mem_funct3 == 3'b000 ? {{(XLEN-8){ld_b[7]}}, ld_b} :
              mem_funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, ld_b} :
              mem_funct3 == 3'b001 ? {{(XLEN-16){ld_h[15]}}, ld_h} :
              mem_funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, ld_h} : mem_read_data;
    sel_val = mem_result_src == 2'b01 ? ld_val :
              mem_result_src == 2'b10 ? mem_pc_plus4 : mem_alu_result;
  end
  // Next state: flush beats stall beats capture; a stalled entry retires only once
  always_comb begin
    retire         = wb_valid_q & ~done_q & ~rst;
    wb_valid_d     = wb_valid_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    done_d         = done_q;
    instret_d      = instret_q + (retire ? CNT_W'(1) : CNT_W'(0));
    if (flush) begin
      wb_valid_d = 1'b0;
      done_d     = 1'b0;
    end else if (stall) begin
      done_d = done_q | retire;
    end else begin
      wb_valid_d     = mem_valid;
      wb_reg_write_d = mem_reg_write;
      wb_rd_d        = mem_rd;
      wb_data_d      = sel_val;
      done_d         = 1'b0;
    end
  end
  // MEM/WB register and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      done_q         <= 1'b0;
      instret_q      <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      done_q         <= done_d;
      instret_q      <= instret_d;
    end
  end
  // Register-file write port, also the WB forwarding source; x0 writes suppressed
  always_comb begin
    show     = wb_valid_q & ~rst;
    A3       = show ? wb_rd_q : 5'd0;
    WD3      = show ? wb_data_q : '0;
    WE3      = retire & wb_reg_write_q & (wb_rd_q != 5'd0);
    wb_valid = retire;
    instret  = instret_q;
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vector table plus multi-cycle sequences for writeback_stage
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst, mem_valid, mem_reg_write, stall, flush;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_result_src;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_read_data, mem_pc_plus4;
  logic [4:0]  A3, A3_s;
  logic [31:0] WD3, WD3_s;
  logic        WE3, WE3_s, wb_valid, wb_valid_s;
  logic [31:0] instret;
  logic [3:0]  instret_s;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_cnt;
  int          we_hits;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .mem_result_src(mem_result_src), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .mem_pc_plus4(mem_pc_plus4), .stall(stall), .flush(flush),
    .A3(A3), .WD3(WD3), .WE3(WE3), .wb_valid(wb_valid), .instret(instret)
  );

  writeback_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .mem_result_src(mem_result_src), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .mem_pc_plus4(mem_pc_plus4), .stall(stall), .flush(flush),
    .A3(A3_s), .WD3(WD3_s), .WE3(WE3_s), .wb_valid(wb_valid_s), .instret(instret_s)
  );

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [31:0] exp_wd;
  } vec_t;
  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
    mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_result_src = src;
    mem_funct3 = f3; mem_alu_result = alu; mem_pc_plus4 = pc4;
  endtask

  initial begin
    vecs[0] = '{2'b00, 3'b000, 32'h0000_1234, 32'h0, 5'd3, 32'h0000_1234};
    vecs[1] = '{2'b01, 3'b000, 32'h0000_0003, 32'h0, 5'd4, 32'hFFFF_FF80};
    vecs[2] = '{2'b01, 3'b100, 32'h0000_0001, 32'h0, 5'd5, 32'h0000_007F};
    vecs[3] = '{2'b01, 3'b001, 32'h0000_0002, 32'h0, 5'd6, 32'hFFFF_80FF};
    vecs[4] = '{2'b01, 3'b101, 32'h0000_0000, 32'h0, 5'd8, 32'h0000_7F01};
    vecs[5] = '{2'b01, 3'b010, 32'h0000_0000, 32'h0, 5'd9, 32'h80FF_7F01};
    vecs[6] = '{2'b01, 3'b001, 32'h0000_0003, 32'h0, 5'd10, 32'hFFFF_80FF};
    vecs[7] = '{2'b01, 3'b110, 32'h0000_0001, 32'h0, 5'd11, 32'h80FF_7F01};
    vecs[8] = '{2'b11, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd12, 32'hDEAD_BEEF};
    vecs[9] = '{2'b10, 3'b000, 32'h0000_0055, 32'h0000_0104, 5'd1, 32'h0000_0104};
    mem_read_data = 32'h80FF_7F01;
    stall = 1'b0; flush = 1'b0; rst = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_00AA, 32'h0);
    #1;
    chk("reset_we_pre_edge", {31'd0, WE3}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset_we", {31'd0, WE3}, 32'd0);
      chk("reset_valid", {31'd0, wb_valid}, 32'd0);
      chk("reset_a3", {27'd0, A3}, 32'd0);
      chk("reset_wd3", WD3, 32'd0);
      chk("reset_instret", instret, 32'd0);
    end
    rst = 1'b0;
    step();
    chk("first_we", {31'd0, WE3}, 32'd1);
    chk("first_a3", {27'd0, A3}, 32'd5);
    chk("first_instret", instret, 32'd0);
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, vecs[i].rd, vecs[i].src, vecs[i].f3, vecs[i].alu, vecs[i].pc4);
      step();
      exp_cnt++;
      chk($sformatf("vec%0d_we", i), {31'd0, WE3}, 32'd1);
      chk($sformatf("vec%0d_a3", i), {27'd0, A3}, {27'd0, vecs[i].rd});
      chk($sformatf("vec%0d_wd3", i), WD3, vecs[i].exp_wd);
      chk($sformatf("vec%0d_instret", i), instret, exp_cnt);
    end
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h0000_0777, 32'h0);
    step();
    exp_cnt++;
    chk("x0_we", {31'd0, WE3}, 32'd0);
    chk("x0_valid", {31'd0, wb_valid}, 32'd1);
    drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h0000_0070, 32'h0);
    step();
    exp_cnt++;
    chk("x0_instret", instret, exp_cnt);
    chk("stall_we_first", {31'd0, WE3}, 32'd1);
    chk("stall_wd3", WD3, 32'h0000_0070);
    we_hits = 1;
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd13, 2'b00, 3'b000, 32'h0000_0999, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (WE3) we_hits++;
      chk("stall_a3_hold", {27'd0, A3}, 32'd7);
    end
    exp_cnt++;
    chk("stall_we_hits", we_hits, 32'd1);
    chk("stall_instret", instret, exp_cnt);
    stall = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'h0000_0909, 32'h0);
    step();
    chk("fs_we_cap", {31'd0, WE3}, 32'd1);
    stall = 1'b1;
    step();
    exp_cnt++;
    chk("fs_we_held", {31'd0, WE3}, 32'd0);
    flush = 1'b1;
    step();
    chk("fs_valid", {31'd0, wb_valid}, 32'd0);
    chk("fs_we", {31'd0, WE3}, 32'd0);
    chk("fs_a3", {27'd0, A3}, 32'd0);
    chk("fs_instret", instret, exp_cnt);
    step();
    chk("fs_instret2", instret, exp_cnt);
    flush = 1'b0; stall = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 5'd2, 2'b00, 3'b000, 32'h0000_0001, 32'h0);
    for (int i = 0; i < 18; i++) step();
    chk("wrap_instret4", {28'd0, instret_s}, 32'd1);
    chk("wrap_instret32", instret, 32'd17);
    chk("wrap_we_noreg", {31'd0, WE3}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
